// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage owning the PC, driving the ROM and filling the IF/ID register
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        stall_ifid,
  input  logic        flush,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] rom_inst_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic [31:0] fetch_count_o
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pend_tgt, tgt;
  logic pend_v, active, advance, squash, capture;
  always_comb begin
    state_n = state == IDLE ? RUN : (stall_pc ? HOLD : RUN);
    active = state != IDLE;
    advance = active && !stall_pc;
    tgt = {branch_target_i[31:2], 2'b00};
    pc_n = (pend_v && !flush) ? pend_tgt : (branch_flag_i ? tgt : pc + 32'd4);
`ifdef FETCH_DELAY_SLOT_EN
    squash = 1'b0;
`else
    squash = branch_flag_i || pend_v;
`endif
    capture = !flush && !stall_ifid && !stall_pc && active && !squash;
  end
  assign rom_ce_o = active;
  assign rom_addr_o = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      pend_v <= 1'b0;
      pend_tgt <= 32'd0;
      id_pc_o <= 32'd0;
      id_inst_o <= 32'd0;
      id_valid_o <= 1'b0;
      fetch_count_o <= 32'd0;
    end else begin
      state <= state_n;
      if (advance) pc <= pc_n;
      pend_v <= flush ? 1'b0 : (branch_flag_i && stall_pc) ? 1'b1 : advance ? 1'b0 : pend_v;
      if (branch_flag_i && stall_pc) pend_tgt <= tgt;
      if (capture) begin
        id_pc_o <= pc;
        id_inst_o <= rom_inst_i;
        id_valid_o <= 1'b1;
        fetch_count_o <= fetch_count_o + 32'd1;
      end else if (flush || !stall_ifid) begin
        id_pc_o <= 32'd0;
        id_inst_o <= 32'd0;
        id_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench with a cycle-level reference model
module tb_if_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, stall_pc = 1'b0, stall_ifid = 1'b0, flush = 1'b0, branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0, rom_inst_i;
  logic rom_ce_o, id_valid_o;
  logic [31:0] rom_addr_o, id_pc_o, id_inst_o, fetch_count_o;
  int checks = 0, failures = 0;
  bit started = 0;
  bit m_run, m_pend_v, m_valid;
  logic [31:0] m_pc, m_pend, m_id_pc, m_id_inst, m_count;
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction
  assign rom_inst_i = rom_ce_o ? rom(rom_addr_o) : 32'd0;
  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush(flush),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i), .rom_inst_i(rom_inst_i),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .id_valid_o(id_valid_o), .fetch_count_o(fetch_count_o)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_pend_v = 0; m_pend = 0; m_pc = 32'd0;
      m_id_pc = 0; m_id_inst = 0; m_valid = 0; m_count = 0;
      started = 1;
    end else begin
      bit redirected;
`ifdef FETCH_DELAY_SLOT_EN
      redirected = 0;
`else
      redirected = branch_flag_i || m_pend_v;
`endif
      if (flush || (!stall_ifid && (stall_pc || !m_run || redirected))) begin
        m_id_pc = 0; m_id_inst = 0; m_valid = 0;
      end else if (!stall_ifid) begin
        m_id_pc = m_pc; m_id_inst = rom(m_pc); m_valid = 1; m_count = m_count + 1;
      end
      if (m_run && !stall_pc) begin
        if (m_pend_v && !flush) m_pc = m_pend;
        else if (branch_flag_i) m_pc = branch_target_i & ~32'd3;
        else m_pc = m_pc + 4;
      end
      if (flush) m_pend_v = 0;
      else if (branch_flag_i && stall_pc) begin m_pend_v = 1; m_pend = branch_target_i & ~32'd3; end
      else if (m_run && !stall_pc) m_pend_v = 0;
      m_run = 1;
    end
  end
  always @(negedge clk) if (started) begin
    chk("rom_ce", {31'd0, rom_ce_o}, {31'd0, m_run});
    chk("rom_addr", rom_addr_o, m_pc);
    chk("id_pc", id_pc_o, m_id_pc);
    chk("id_inst", id_inst_o, m_id_inst);
    chk("id_valid", {31'd0, id_valid_o}, {31'd0, m_valid});
    chk("fetch_count", fetch_count_o, m_count);
  end
  task automatic cyc(input logic r, input logic sp, input logic si, input logic fl, input logic bf, input logic [31:0] bt);
    rst = r; stall_pc = sp; stall_ifid = si; flush = fl; branch_flag_i = bf; branch_target_i = bt;
    @(negedge clk);
  endtask
  logic [31:0] resume;
  initial begin
    @(negedge clk);
    chk("lit_reset_ce", {31'd0, rom_ce_o}, 32'd0);
    chk("lit_reset_addr", rom_addr_o, 32'd0);
    chk("lit_reset_count", fetch_count_o, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_ce_on", {31'd0, rom_ce_o}, 32'd1);
    chk("lit_first_bubble", {31'd0, id_valid_o}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_inst0", id_inst_o, 32'h11);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_inst1", id_inst_o, 32'h22);
    chk("lit_pc1", id_pc_o, 32'h4);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0);
    chk("lit_stall_addr", rom_addr_o, 32'h8);
    chk("lit_stall_inst", id_inst_o, 32'h22);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_release_inst", id_inst_o, 32'h33);
    chk("lit_release_addr", rom_addr_o, 32'hC);
    chk("lit_count3", fetch_count_o, 32'd3);
    cyc(0, 1, 0, 0, 0, 0);
    chk("lit_bubble_valid", {31'd0, id_valid_o}, 32'd0);
    chk("lit_bubble_inst", id_inst_o, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_at_0x10", rom_addr_o, 32'h10);
    cyc(0, 0, 0, 0, 1, 32'h41);
    chk("lit_branch_addr", rom_addr_o, 32'h40);
`ifdef FETCH_DELAY_SLOT_EN
    chk("lit_delay_slot_valid", {31'd0, id_valid_o}, 32'd1);
    chk("lit_delay_slot_pc", id_pc_o, 32'h10);
    chk("lit_delay_slot_count", fetch_count_o, 32'd5);
`else
    chk("lit_squash_valid", {31'd0, id_valid_o}, 32'd0);
    chk("lit_squash_count", fetch_count_o, 32'd4);
`endif
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_target_inst", id_inst_o, 32'h121);
    cyc(0, 1, 0, 0, 1, 32'h80);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_pending_jump", rom_addr_o, 32'h80);
    resume = m_pc + 4;
    cyc(0, 1, 0, 0, 1, 32'h200);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_flush_pending", rom_addr_o, resume);
    cyc(0, 1, 0, 0, 1, 32'h100);
    cyc(0, 1, 0, 0, 1, 32'h200);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_pending_overwrite", rom_addr_o, 32'h200);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("lit_flush_valid", {31'd0, id_valid_o}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    chk("lit_top_addr", rom_addr_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_wrap_addr", rom_addr_o, 32'h0);
    chk("lit_wrap_pc", id_pc_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 1, 32'h300);
    chk("lit_midrst_ce", {31'd0, rom_ce_o}, 32'd0);
    chk("lit_midrst_addr", rom_addr_o, 32'd0);
    chk("lit_midrst_count", fetch_count_o, 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("lit_after_rst_inst", id_inst_o, 32'h33);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
